// File: rtl/store_drain_unit.sv
// store_drain_unit
//   Drains the top entry of the store buffer to data memory once that store
//   has reached the ROB head. Only one write is in flight at a time. When
//   the write completes, the unit pops the store buffer and reports the
//   retired ROB index.
//
//   Optional feature: define STORE_MISALIGN_CHECK_EN to flag misaligned
//   stores. These are SH with addr[0]=1, or SW with addr[1:0]!=0. A flagged
//   store skips the memory write and is retired with store_exception=1.
//   Without the macro, store_exception is tied low and misaligned stores
//   are written with the low address bits truncated.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   sb_*                top-of-store-buffer entry (empty, addr, data, funct3, rob idx)
//   rob_head_*          ROB head valid/index, used for eligibility
//   dmem_ready/resp     memory accept and completion pulse
//   dmem_write/addr/wdata/wmask  memory write request
//   sb_pop              pops the store buffer
//   rob_store_done(_idx)  store retired, with its ROB index
//   store_exception     misaligned store flagged (optional feature)
//   store_busy          FSM not idle
module store_drain_unit #(
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sb_empty,
  input  logic [31:0]          sb_addr,
  input  logic [31:0]          sb_data,
  input  logic [2:0]           sb_funct3,
  input  logic [ROB_IDX_W-1:0] sb_rob_idx,
  input  logic                 rob_head_valid,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  input  logic                 dmem_ready,
  input  logic                 dmem_resp,
  output logic                 dmem_write,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  output logic [3:0]           dmem_wmask,
  output logic                 sb_pop,
  output logic                 rob_store_done,
  output logic [ROB_IDX_W-1:0] rob_store_done_idx,
  output logic                 store_exception,
  output logic                 store_busy
);

  // state | meaning
  // IDLE  | waiting for the top store to become the ROB head
  // REQ   | write request held on the bus until dmem_ready
  // WAIT  | request accepted, waiting for the dmem_resp completion
  // DONE  | one-cycle pop and retire pulse
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [29:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wmask_q, wmask_d;
  logic [ROB_IDX_W-1:0]   rob_idx_q, rob_idx_d;
  // Set for the cycle after DONE. During that cycle the buffer top may still
  // show the store that was just popped, so eligibility is masked.
  logic                   rearm_blk_q, rearm_blk_d;
  logic                   eligible;
  logic [3:0]             mask_new;
  logic [31:0]            wdata_new;
`ifdef STORE_MISALIGN_CHECK_EN
  logic                   exc_q, exc_d;
  logic                   misaligned;
`endif

  assign eligible = !sb_empty && rob_head_valid && (rob_head_idx == sb_rob_idx)
                    && !rearm_blk_q;

  always_comb begin
    mask_new  = 4'b0000;
    wdata_new = sb_data;
    case (sb_funct3)
      3'b000: begin
        mask_new  = 4'b0001 << sb_addr[1:0];
        wdata_new = {4{sb_data[7:0]}};
      end
      3'b001: begin
        mask_new  = 4'b0011 << {sb_addr[1], 1'b0};
        wdata_new = {2{sb_data[15:0]}};
      end
      3'b010: begin
        mask_new  = 4'b1111;
        wdata_new = sb_data;
      end
      default: begin
        mask_new  = 4'b0000;
        wdata_new = sb_data;
      end
    endcase
  end

`ifdef STORE_MISALIGN_CHECK_EN
  assign misaligned = ((sb_funct3 == 3'b001) && sb_addr[0]) ||
                      ((sb_funct3 == 3'b010) && (sb_addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rob_idx_d   = rob_idx_q;
    rearm_blk_d = (state_q == DONE);
`ifdef STORE_MISALIGN_CHECK_EN
    exc_d       = exc_q;
`endif
    case (state_q)
      IDLE: begin
        if (eligible) begin
          addr_d    = sb_addr[31:2];
          wdata_d   = wdata_new;
          wmask_d   = mask_new;
          rob_idx_d = sb_rob_idx;
`ifdef STORE_MISALIGN_CHECK_EN
          exc_d     = misaligned;
          state_d   = misaligned ? DONE : REQ;
`else
          state_d   = REQ;
`endif
        end
      end
      REQ: begin
        if (dmem_ready) begin
          state_d = dmem_resp ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dmem_resp) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rob_idx_q   <= '0;
      rearm_blk_q <= 1'b0;
`ifdef STORE_MISALIGN_CHECK_EN
      exc_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rob_idx_q   <= rob_idx_d;
      rearm_blk_q <= rearm_blk_d;
`ifdef STORE_MISALIGN_CHECK_EN
      exc_q       <= exc_d;
`endif
    end
  end

  assign dmem_write         = (state_q == REQ);
  assign dmem_addr          = {addr_q, 2'b00};
  assign dmem_wdata         = wdata_q;
  assign dmem_wmask         = wmask_q;
  assign sb_pop             = (state_q == DONE);
  assign rob_store_done     = (state_q == DONE);
  assign rob_store_done_idx = rob_idx_q;
  assign store_busy         = (state_q != IDLE);
`ifdef STORE_MISALIGN_CHECK_EN
  assign store_exception    = (state_q == DONE) && exc_q;
`else
  assign store_exception    = 1'b0;
`endif

endmodule

// File: tb/tb_store_drain_unit.sv
module tb_store_drain_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sb_empty;
  logic [31:0] sb_addr;
  logic [31:0] sb_data;
  logic [2:0]  sb_funct3;
  logic [4:0]  sb_rob_idx;
  logic        rob_head_valid;
  logic [4:0]  rob_head_idx;
  logic        dmem_ready;
  logic        dmem_resp;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        sb_pop;
  logic        rob_store_done;
  logic [4:0]  rob_store_done_idx;
  logic        store_exception;
  logic        store_busy;

  int n_pass  = 0;
  int n_total = 0;

`ifdef STORE_MISALIGN_CHECK_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  store_drain_unit #(.ROB_IDX_W(5)) dut (
    .clk(clk), .rst(rst), .sb_empty(sb_empty), .sb_addr(sb_addr),
    .sb_data(sb_data), .sb_funct3(sb_funct3), .sb_rob_idx(sb_rob_idx),
    .rob_head_valid(rob_head_valid), .rob_head_idx(rob_head_idx),
    .dmem_ready(dmem_ready), .dmem_resp(dmem_resp), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .sb_pop(sb_pop), .rob_store_done(rob_store_done),
    .rob_store_done_idx(rob_store_done_idx), .store_exception(store_exception),
    .store_busy(store_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f3;
    int          rdly;
    logic [31:0] ea;
    logic [3:0]  em;
    logic [31:0] ewd;
    bit          chk_wd;
    bit          exc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: expected memory write for a store, from the size/lane rules.
  task automatic ref_fields(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                            output logic [31:0] ea, output logic [3:0] em,
                            output logic [31:0] ewd, output bit exc);
    ea  = a - (a % 32'd4);
    exc = 1'b0;
    case (f3)
      3'd0: begin em = 4'(32'd1 << (a % 32'd4)); ewd = {24'b0, d[7:0]} * 32'h01010101; end
      3'd1: begin em = 4'(32'd3 << (a & 32'd2)); ewd = {16'b0, d[15:0]} * 32'h00010001;
                  exc = EXC_ON && (a % 32'd2 != 0); end
      3'd2: begin em = 4'hF; ewd = d; exc = EXC_ON && (a % 32'd4 != 0); end
      default: begin em = 4'h0; ewd = d; end
    endcase
  endtask

  // Presents one store as eligible on the current cycle (cycle 0) and plays
  // the memory side: ready after rdly extra request cycles, response either
  // in the accept cycle (same) or rspdly cycles after the first WAIT cycle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic [4:0] idx, input int rdly, input int rspdly,
                         input bit same, input bit spur,
                         input logic [31:0] ea, input logic [3:0] em,
                         input logic [31:0] ewd, input bit chk_wd, input bit exc);
    int cyc, nwr, pop_cyc, acc_cyc, exp_pop;
    bit accepted, wr_after_acc, unstable;
    sb_addr = a; sb_data = d; sb_funct3 = f3; sb_rob_idx = idx;
    sb_empty = 1'b0; rob_head_valid = 1'b1; rob_head_idx = idx;
    dmem_ready = 1'b0; dmem_resp = spur;
    cyc = 0; nwr = 0; pop_cyc = -1; acc_cyc = -1;
    accepted = 1'b0; wr_after_acc = 1'b0; unstable = 1'b0;
    while (pop_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      dmem_ready = 1'b0;
      dmem_resp  = 1'b0;
      if (sb_pop) begin
        pop_cyc = cyc;
        chk("done_pulse", 32'(rob_store_done), 32'd1);
        chk("done_idx", 32'(rob_store_done_idx), 32'(idx));
        chk("store_exc", 32'(store_exception), 32'(exc));
        chk("write_in_done", 32'(dmem_write), 32'd0);
      end else if (dmem_write) begin
        if (accepted) wr_after_acc = 1'b1;
        nwr++;
        if (nwr == 1) begin
          chk("wr_addr", dmem_addr, ea);
          chk("wr_mask", 32'(dmem_wmask), 32'(em));
          if (chk_wd) chk("wr_data", dmem_wdata, ewd);
        end else if (dmem_addr !== ea || dmem_wmask !== em ||
                     (chk_wd && dmem_wdata !== ewd)) begin
          unstable = 1'b1;
        end
        if (nwr > rdly && !accepted) begin
          dmem_ready = 1'b1;
          accepted   = 1'b1;
          acc_cyc    = cyc;
          if (same) dmem_resp = 1'b1;
        end
      end else if (accepted && !same && cyc == acc_cyc + 1 + rspdly) begin
        dmem_resp = 1'b1;
      end
    end
    exp_pop = exc ? 1 : (same ? rdly + 2 : rdly + 3 + rspdly);
    chk("pop_latency", 32'(pop_cyc), 32'(exp_pop));
    chk("write_cycles", 32'(nwr), exc ? 32'd0 : 32'(rdly + 1));
    chk("write_after_accept", 32'(wr_after_acc), 32'd0);
    chk("req_stable", 32'(unstable), 32'd0);
    // Buffer top is still the popped store for one cycle: must not re-arm.
    @(negedge clk);
    chk("no_rearm_busy", 32'(store_busy), 32'd0);
    chk("pop_one_cycle", 32'(sb_pop), 32'd0);
    sb_empty = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rd, ea, ewd;
    logic [3:0]  em;
    logic [2:0]  rf;
    logic [4:0]  ridx;
    bit          rexc, rsame, bad;
    int          rr, rs;

    vecs[0] = '{32'h1004, 32'hDEADBEEF, 3'b010, 0, 32'h1004, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1] = '{32'h2003, 32'h000000A5, 3'b000, 0, 32'h2000, 4'h8, 32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[2] = '{32'h2002, 32'h0000BEEF, 3'b001, 4, 32'h2000, 4'hC, 32'hBEEFBEEF, 1'b1, 1'b0};
    vecs[3] = '{32'h0010, 32'h00000077, 3'b000, 1, 32'h0010, 4'h1, 32'h77777777, 1'b1, 1'b0};
    vecs[4] = '{32'h0000, 32'h1234ABCD, 3'b001, 0, 32'h0000, 4'h3, 32'hABCDABCD, 1'b1, 1'b0};
    vecs[5] = '{32'h0044, 32'h55555555, 3'b111, 2, 32'h0044, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[6] = '{32'h3002, 32'hCAFEF00D, 3'b010, 0, 32'h3000, 4'hF, 32'hCAFEF00D, 1'b1, EXC_ON};
    vecs[7] = '{32'h0005, 32'hFFFFFF12, 3'b000, 0, 32'h0004, 4'h2, 32'h12121212, 1'b1, 1'b0};
    vecs[8] = '{32'h0007, 32'h00005678, 3'b001, 1, 32'h0004, 4'hC, 32'h56785678, 1'b1, EXC_ON};

    rst = 1'b1; sb_empty = 1'b1; sb_addr = '0; sb_data = '0; sb_funct3 = '0;
    sb_rob_idx = '0; rob_head_valid = 1'b0; rob_head_idx = '0;
    dmem_ready = 1'b0; dmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_write", 32'(dmem_write), 32'd0);
    chk("rst_pop", 32'(sb_pop), 32'd0);
    chk("rst_busy", 32'(store_busy), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_mask", 32'(dmem_wmask), 32'd0);
    chk("rst_exc", 32'(store_exception), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].a, vecs[i].d, vecs[i].f3, 5'(i + 3), vecs[i].rdly, 0, 1'b0, 1'b0,
              vecs[i].ea, vecs[i].em, vecs[i].ewd, vecs[i].chk_wd, vecs[i].exc);
    end

    // ROB head not matching for 10 cycles, then head invalid with match.
    sb_addr = 32'h40; sb_data = 32'h11223344; sb_funct3 = 3'b010; sb_rob_idx = 5'd9;
    sb_empty = 1'b0; rob_head_valid = 1'b1; rob_head_idx = 5'd10;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dmem_write || store_busy) bad = 1'b1;
    end
    rob_head_valid = 1'b0; rob_head_idx = 5'd9;
    repeat (3) begin
      @(negedge clk);
      if (dmem_write || store_busy) bad = 1'b1;
    end
    chk("no_arm_before_match", 32'(bad), 32'd0);
    run_txn(32'h40, 32'h11223344, 3'b010, 5'd9, 0, 0, 1'b0, 1'b0,
            32'h40, 4'hF, 32'h11223344, 1'b1, 1'b0);

    // Reset while waiting for the memory response.
    sb_addr = 32'h1004; sb_data = 32'hDEADBEEF; sb_funct3 = 3'b010; sb_rob_idx = 5'd7;
    sb_empty = 1'b0; rob_head_valid = 1'b1; rob_head_idx = 5'd7;
    @(negedge clk);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("wait_busy", 32'(store_busy), 32'd1);
    chk("wait_no_write", 32'(dmem_write), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(store_busy), 32'd0);
    chk("arst_addr", dmem_addr, 32'd0);
    chk("arst_wdata", dmem_wdata, 32'd0);
    chk("arst_mask", 32'(dmem_wmask), 32'd0);
    chk("arst_idx", 32'(rob_store_done_idx), 32'd0);
    sb_empty = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_resp = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      dmem_resp = 1'b0;
      if (sb_pop || rob_store_done || store_busy || dmem_write) bad = 1'b1;
    end
    chk("aborted_not_popped", 32'(bad), 32'd0);

    // Randomized stores against the reference model.
    for (int n = 0; n < 40; n++) begin
      ra   = $urandom;
      rd   = $urandom;
      rf   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      ridx = 5'($urandom_range(0, 31));
      rr   = $urandom_range(0, 3);
      rs   = $urandom_range(0, 2);
      rsame = ($urandom_range(0, 3) == 0);
      ref_fields(ra, rd, rf, ea, em, ewd, rexc);
      run_txn(ra, rd, rf, ridx, rr, rs, rsame, $urandom_range(0, 1) == 1,
              ea, em, ewd, rf <= 3'd2, rexc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
